// File: rtl/bcd_display_mux.sv
// bcd_display_mux
//   Two-digit multiplexed seven-segment driver. Tens/units BCD digits are
//   captured into a shadow register and copied into the display register
//   only at a frame boundary, so a frame never shows a torn pair. The two
//   digits share one active-low segment bus; each digit slot starts with an
//   anode-off gap to suppress ghosting.
//
//   Parameters:
//     REFRESH_DIV  clock cycles per digit slot (>= 4)
//     BLANK_CYCLES anode-off cycles at the start of each slot (< REFRESH_DIV)
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     load       capture d_in/u_in into the shadow register
//     d_in       tens BCD digit
//     u_in       units BCD digit
//     seg        active-low segments, seg[0]=a .. seg[6]=g
//     an         active-low digit enables, an[0]=units, an[1]=tens
//     frame_tick one-cycle pulse at the start of each frame
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 keeps the tens
//                            slot dark for its whole duration.
module bcd_display_mux #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] d_in,
   input  logic [3:0] u_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_tick
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   // Active-high {g,f,e,d,c,b,a}; codes 10..15 show a dash.
   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      logic [6:0] p;
      case (digit)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h40;
      endcase
      return p;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic [7:0]       shadow_q, shadow_d;
   logic [7:0]       disp_q, disp_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             tick_q, tick_d;

   logic             wrap;
   logic             frame_end;
   logic             lit;
   logic [3:0]       digit;

   always_comb begin
      wrap      = (cnt_q == CNT_LAST);
      // Frame ends when the tens slot wraps back to the units slot.
      frame_end = wrap && sel_q;

      cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
      sel_d    = wrap ? ~sel_q : sel_q;
      shadow_d = load ? {d_in, u_in} : shadow_q;
      // Pre-edge shadow is used, so a load on the boundary edge waits a frame.
      disp_d   = frame_end ? shadow_q : disp_q;
      tick_d   = frame_end;

      digit = sel_q ? disp_q[7:4] : disp_q[3:0];
      lit   = (cnt_q >= CNT_BLANK);
`ifdef LEADING_ZERO_BLANK_EN
      if (sel_q && (disp_q[7:4] == 4'd0)) lit = 1'b0;
`endif

      an_d  = 2'b11;
      seg_d = 7'h7F;
      if (lit) begin
         an_d  = sel_q ? 2'b01 : 2'b10;
         seg_d = ~seg_pattern(digit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         shadow_q <= 8'h00;
         disp_q   <= 8'h00;
         seg_q    <= 7'h7F;
         an_q     <= 2'b11;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         tick_q   <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule
